// File: rtl/rx_capture_buffer.sv
// rtl/rx_capture_buffer.sv - armed/triggered 256-bit snapshot capture replayed as a 64-bit AXI-Stream
// Words are written to a simple dual-port RAM, then streamed out through a word prefetch and output register.
module rx_capture_buffer #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [255:0]        rx_data,
  input  logic                rx_valid,
  input  logic                arm,
  input  logic                trig_in,
  input  logic [DEPTH_LOG2:0] capture_len,
  output logic [63:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [1:0]          state,
  output logic                done
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEN = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE      = (DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2:0]   len_q, len_d;
  logic [DEPTH_LOG2:0]   wr_cnt_q, wr_cnt_d;
  logic                  done_q, done_d;
  logic                  wr_en;
  logic [DEPTH_LOG2:0]   eff_len;

  logic [255:0]          mem [DEPTH];
  logic [255:0]          ram_q;
  logic                  ram_valid_q, ram_last_q;
  logic [DEPTH_LOG2:0]   rd_addr_q;
  logic [255:0]          cur_q;
  logic                  cur_valid_q, cur_last_q;
  logic [1:0]            beat_q;
  logic [63:0]           tdata_q;
  logic                  tvalid_q, tlast_q;

  logic in_readout, final_hs, out_load, cur_take, cur_load, rd_en;

  assign eff_len = (capture_len == '0 || capture_len > FULL_LEN) ? FULL_LEN : capture_len;

  assign in_readout = (state_q == ST_READOUT);
  assign final_hs   = tvalid_q & m_axis_tready & tlast_q;
  assign out_load   = in_readout & cur_valid_q & (~tvalid_q | m_axis_tready);
  assign cur_take   = out_load & (beat_q == 2'd3);
  assign cur_load   = ram_valid_q & (~cur_valid_q | cur_take);
  assign rd_en      = in_readout & (rd_addr_q != len_q) & (~ram_valid_q | cur_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          len_d    = eff_len;
          wr_cnt_d = '0;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (rx_valid && trig_in) begin
          wr_en    = 1'b1;
          wr_cnt_d = ONE;
          state_d  = (len_q == ONE) ? ST_READOUT : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (rx_valid) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + ONE;
          if (wr_cnt_d == len_q) state_d = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (final_hs) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM kept reset-free so it maps onto block RAM; wr_cnt_q is 0 while ARMED
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q[DEPTH_LOG2-1:0]] <= rx_data;
    if (rd_en) ram_q <= mem[rd_addr_q[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q   <= '0;
      ram_valid_q <= 1'b0;
      ram_last_q  <= 1'b0;
      cur_q       <= '0;
      cur_valid_q <= 1'b0;
      cur_last_q  <= 1'b0;
      beat_q      <= 2'd0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      rd_addr_q <= in_readout ? (rd_en ? rd_addr_q + ONE : rd_addr_q) : '0;
      if (rd_en) begin
        ram_valid_q <= 1'b1;
        ram_last_q  <= (rd_addr_q == len_q - ONE);
      end else if (cur_load) begin
        ram_valid_q <= 1'b0;
      end
      if (out_load) begin
        beat_q   <= beat_q + 2'd1;
        tdata_q  <= cur_q[{beat_q, 6'd0} +: 64];
        tlast_q  <= cur_last_q & (beat_q == 2'd3);
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      // The prefetched word refills the current-word slot on the same cycle its last beat leaves
      if (cur_load) begin
        cur_q       <= ram_q;
        cur_valid_q <= 1'b1;
        cur_last_q  <= ram_last_q;
        beat_q      <= 2'd0;
      end else if (cur_take) begin
        cur_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign state         = state_q;
  assign done          = done_q;
endmodule
